mem_recorder: RTL
=================

Name: mem_recorder

Overview:
- Capture-side counterpart to the pattern-finder stimulus ROM player.
- Accepts pattern-finder results (key half-strip, comparator code, pattern ID) on a valid strobe.
- Compares each result against the expected values delivered alongside it, then writes result plus mismatch flag into a capture RAM.
- Drives the `increment` strobe that advances the stimulus player; a readout port lets the bench or slow control dump the captured results.

Parameters:
- MXADRB, 12, capture RAM address width.
- RAMLENGTH, 1<<MXADRB, capture RAM depth in entries.
- MXERRB, 16, width of the saturating mismatch counter.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- arm  in  1  single-cycle pulse; clears counters and starts capture.
- stop  in  1  single-cycle pulse; ends capture.
- valid  in  1  result strobe; result and expect inputs are valid this cycle.
- key_hs  in  8  found key half-strip.
- ccode  in  12  found comparator code.
- pat  in  4  found pattern ID.
- key_hs_expect  in  8  expected key half-strip.
- ccode_expect  in  12  expected comparator code.
- pat_expect  in  4  expected pattern ID.
- increment  out  1  advance pulse to the stimulus player; registered.
- rd_adr  in  MXADRB  readout address.
- rd_data  out  25  readout data: [24] mismatch flag, [23:20] pat, [19:8] ccode, [7:0] key_hs.
- wr_cnt  out  MXADRB+1  number of entries written since the last arm.
- busy  out  1  high in CAPTURE.
- full  out  1  high once RAMLENGTH entries have been written.
- err_cnt  out  MXERRB  mismatch count; saturates at all-ones.
- first_err_vld  out  1  at least one mismatch seen since the last arm.
- first_err_adr  out  MXADRB  RAM address of the first mismatching entry.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE.
  - increment, rd_data, wr_cnt, busy, full, err_cnt, first_err_vld and first_err_adr all go to 0.
  - RAM contents are not cleared.
  - Reset mid-capture aborts immediately; no write happens on that edge.
- State machine has three states: IDLE, CAPTURE, DONE.
  - IDLE: arm → CAPTURE. stop and valid are ignored.
  - CAPTURE: busy=1.
  - DONE: arm → CAPTURE. valid is ignored.
- Arm behaviour (any state):
  - On the arm edge: wr_cnt, err_cnt, first_err_vld, first_err_adr and full clear to 0; state becomes CAPTURE.
  - A valid in the same cycle as arm is dropped.
  - Arm during CAPTURE restarts capture at address 0.
- Accepted sample (valid=1 in CAPTURE, no arm):
  - Write {mismatch, pat, ccode, key_hs} at address wr_cnt[MXADRB-1:0].
  - wr_cnt increments by 1.
  - mismatch = (key_hs!=key_hs_expect) | (ccode!=ccode_expect) | (pat!=pat_expect).
- Mismatch handling on an accepted sample:
  - err_cnt increments unless already all-ones.
  - If first_err_vld=0: first_err_adr takes the write address and first_err_vld is set.
- increment:
  - Is 1 for exactly one cycle following each accepted sample (1-cycle latency).
  - Is never asserted outside CAPTURE-accepted samples.
- Full boundary:
  - When the accepted sample is written at address RAMLENGTH-1, wr_cnt becomes RAMLENGTH, full=1 and state becomes DONE on the same edge.
  - No wrap-around: address 0 is never overwritten until the next arm.
- Stop:
  - stop in CAPTURE → DONE.
  - If valid is also high that cycle, the sample is written first, then DONE.
  - stop in IDLE or DONE is ignored.
- Simultaneous arm and stop: arm wins.
- Readout:
  - rd_data is a registered synchronous read: rd_data = RAM[rd_adr] one cycle after rd_adr is presented.
  - The read port is independent of the write port and legal in any state.
  - A read of the address being written in the same cycle returns the old data.
- Width rules:
  - wr_cnt is MXADRB+1 bits so the value RAMLENGTH is representable.
  - The RAM address is wr_cnt[MXADRB-1:0].

Test Plan:
- Reset then arm; 4 valid samples, all matching (key_hs=8'h10, ccode=12'h3A5, pat=4'hA) → wr_cnt=4, err_cnt=0, first_err_vld=0, 4 increment pulses each 1 cycle after valid; rd_adr=2 returns 25'h0A3A510 one cycle later.
- Arm; samples 0..5, with sample 3 having pat=4'h9 vs expect 4'hA and sample 5 having ccode off by 1 → err_cnt=2, first_err_adr=3, RAM[3][24]=1, RAM[4][24]=0.
- MXADRB=3; arm, 10 back-to-back valids → full=1 and DONE after the 8th, wr_cnt=8, only 8 increment pulses, RAM[0] still holds sample 0.
- stop with valid in the same cycle at sample 5 → wr_cnt=6, busy=0; later valids produce no write and no increment; stop in IDLE leaves state IDLE.
- Arm and stop in the same cycle mid-capture → CAPTURE restarts, wr_cnt=0, err_cnt=0, valid that cycle dropped; reset_n=0 mid-capture → all outputs 0 next cycle, IDLE.
- MXERRB=2; 5 mismatching samples → err_cnt holds 2'b11, first_err_adr=0.

Source files
------------

// File: rtl/mem_recorder.sv
// mem_recorder: capture-side recorder that checks pattern-finder results against expected values and stores them in a RAM.
//   clock_i/reset_n_i : rising-edge clock, synchronous active-low reset
//   arm_i/stop_i      : start (clears counters) / end capture pulses; arm wins over stop
//   valid_i + result  : key_hs_i, ccode_i, pat_i with expected key_hs_expect_i, ccode_expect_i, pat_expect_i
//   increment_o       : one-cycle advance pulse after each accepted sample
//   rd_adr_i/rd_data_o: registered readout {mismatch, pat, ccode, key_hs}
//   wr_cnt_o, busy_o, full_o, err_cnt_o, first_err_vld_o, first_err_adr_o : capture status
module mem_recorder #(
    parameter int MXADRB    = 12,
    parameter int RAMLENGTH = 1 << MXADRB,
    parameter int MXERRB    = 16
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              arm_i,
    input  logic              stop_i,
    input  logic              valid_i,
    input  logic [7:0]        key_hs_i,
    input  logic [11:0]       ccode_i,
    input  logic [3:0]        pat_i,
    input  logic [7:0]        key_hs_expect_i,
    input  logic [11:0]       ccode_expect_i,
    input  logic [3:0]        pat_expect_i,
    output logic              increment_o,
    input  logic [MXADRB-1:0] rd_adr_i,
    output logic [24:0]       rd_data_o,
    output logic [MXADRB:0]   wr_cnt_o,
    output logic              busy_o,
    output logic              full_o,
    output logic [MXERRB-1:0] err_cnt_o,
    output logic              first_err_vld_o,
    output logic [MXADRB-1:0] first_err_adr_o
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
    state_t            state_q, state_d;
    logic [MXADRB:0]   wr_cnt_q, wr_cnt_d;
    logic [MXERRB-1:0] err_cnt_q, err_cnt_d;
    logic              first_err_vld_q, first_err_vld_d;
    logic [MXADRB-1:0] first_err_adr_q, first_err_adr_d;
    logic              full_q, full_d;
    logic              increment_q;
    logic [24:0]       rd_data_q;
    logic [24:0]       ram [RAMLENGTH];
    logic [MXADRB-1:0] wr_adr;
    logic              accept, mismatch;
    assign wr_adr   = wr_cnt_q[MXADRB-1:0];
    // arm takes priority, so a valid in the arm cycle is dropped
    assign accept   = (state_q == CAPTURE) && valid_i && !arm_i;
    assign mismatch = (key_hs_i != key_hs_expect_i) | (ccode_i != ccode_expect_i) | (pat_i != pat_expect_i);
    always_comb begin
        state_d         = state_q;
        wr_cnt_d        = wr_cnt_q;
        err_cnt_d       = err_cnt_q;
        first_err_vld_d = first_err_vld_q;
        first_err_adr_d = first_err_adr_q;
        full_d          = full_q;
        if (arm_i) begin
            state_d         = CAPTURE;
            wr_cnt_d        = '0;
            err_cnt_d       = '0;
            first_err_vld_d = 1'b0;
            first_err_adr_d = '0;
            full_d          = 1'b0;
        end else if (state_q == CAPTURE) begin
            if (valid_i) begin
                wr_cnt_d = wr_cnt_q + (MXADRB+1)'(1);
                if (mismatch) begin
                    err_cnt_d = &err_cnt_q ? err_cnt_q : err_cnt_q + MXERRB'(1);
                    if (!first_err_vld_q) begin
                        first_err_vld_d = 1'b1;
                        first_err_adr_d = wr_adr;
                    end
                end
                // last RAM slot written: stop here rather than wrap onto address 0
                if (&wr_adr) begin
                    full_d  = 1'b1;
                    state_d = DONE;
                end
            end
            if (stop_i) state_d = DONE;
        end
    end
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q         <= IDLE;
            wr_cnt_q        <= '0;
            err_cnt_q       <= '0;
            first_err_vld_q <= 1'b0;
            first_err_adr_q <= '0;
            full_q          <= 1'b0;
            increment_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_cnt_q        <= wr_cnt_d;
            err_cnt_q       <= err_cnt_d;
            first_err_vld_q <= first_err_vld_d;
            first_err_adr_q <= first_err_adr_d;
            full_q          <= full_d;
            increment_q     <= accept;
        end
    end
    // RAM has no reset; a reset edge suppresses the write
    always_ff @(posedge clock_i) begin
        if (reset_n_i && accept) ram[wr_adr] <= {mismatch, pat_i, ccode_i, key_hs_i};
    end
    // read-before-write: same-address access returns the old word
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) rd_data_q <= '0;
        else rd_data_q <= ram[rd_adr_i];
    end
    assign increment_o     = increment_q;
    assign rd_data_o       = rd_data_q;
    assign wr_cnt_o        = wr_cnt_q;
    assign busy_o          = state_q == CAPTURE;
    assign full_o          = full_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_vld_o = first_err_vld_q;
    assign first_err_adr_o = first_err_adr_q;
endmodule
